// File: rtl/rfphoenix_stmerge_ctrl.sv
// Read-modify-write byte-merge store sequencer for the 256-bit dcache line RAM.
// Optional last-line forwarding is enabled by defining RFPHOENIX_STMERGE_FWD_EN.
module rfphoenix_stmerge_ctrl #(
  parameter int NREQ    = 2,
  parameter int BUSWID  = 128,
  parameter int LINEWID = 256,
  parameter int AWID    = 28,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           i_req,
  output logic [NREQ-1:0]           o_ack,
  input  logic [NREQ*(BUSWID/8)-1:0] i_sel,
  input  logic [NREQ-1:0]           i_lane,
  input  logic [NREQ*AWID-1:0]      i_ladr,
  input  logic [NREQ*BUSWID-1:0]    i_dat,
  input  logic                      i_inv,
  output logic                      o_busy,
  output logic                      o_ram_rd,
  output logic                      o_ram_we,
  output logic [AWID-1:0]           o_ram_adr,
  input  logic [LINEWID-1:0]        i_ram_rdat,
  output logic [LINEWID-1:0]        o_ram_wdat
);

  localparam int         SELW   = BUSWID / 8;
  localparam logic [2:0] LP_LAT = 3'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_ptr;
  logic                r_win;
  logic                w_win;
  logic                w_win_nxt;
  logic                w_cap;
  logic                w_fwd_hit;
  logic [2:0]          r_cnt;
  logic [SELW-1:0]     r_sel;
  logic [SELW-1:0]     w_sel;
  logic [SELW-1:0]     w_m_sel;
  logic                r_lane;
  logic                w_lane;
  logic                w_m_lane;
  logic [AWID-1:0]     r_ladr;
  logic [AWID-1:0]     w_ladr;
  logic [BUSWID-1:0]   r_dat;
  logic [BUSWID-1:0]   w_dat;
  logic [BUSWID-1:0]   w_m_dat;
  logic [LINEWID-1:0]  w_old;
  logic [LINEWID-1:0]  w_merged;
  logic [LINEWID-1:0]  r_ram_wdat;
  logic [NREQ-1:0]     r_ack;
  logic                r_busy;
  logic                r_ram_rd;
  logic                r_ram_we;

  function automatic logic [LINEWID-1:0] f_merge(
    input logic [LINEWID-1:0] old,
    input logic [SELW-1:0]    sel,
    input logic               lane,
    input logic [BUSWID-1:0]  dat
  );
    logic [LINEWID-1:0] mask;
    logic [LINEWID-1:0] wide;
    mask = '0;
    for (int b = 0; b < SELW; b++) begin
      mask[b*8 +: 8] = {8{sel[b]}};
    end
    wide = {{(LINEWID-BUSWID){1'b0}}, dat};
    mask = lane ? (mask << BUSWID) : mask;
    wide = lane ? (wide << BUSWID) : wide;
    return (old & ~mask) | (wide & mask);
  endfunction

  assign w_win     = i_req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_sel     = w_win ? i_sel[2*SELW-1:SELW]     : i_sel[SELW-1:0];
  assign w_lane    = w_win ? i_lane[1]                : i_lane[0];
  assign w_ladr    = w_win ? i_ladr[2*AWID-1:AWID]    : i_ladr[AWID-1:0];
  assign w_dat     = w_win ? i_dat[2*BUSWID-1:BUSWID] : i_dat[BUSWID-1:0];
  assign w_win_nxt = (r_state == S_IDLE) ? w_win : r_win;

  // A forwarded store reaches WR straight from the grant edge, so in IDLE the merge uses the live winner fields.
  assign w_m_sel  = (r_state == S_IDLE) ? w_sel  : r_sel;
  assign w_m_lane = (r_state == S_IDLE) ? w_lane : r_lane;
  assign w_m_dat  = (r_state == S_IDLE) ? w_dat  : r_dat;
  assign w_merged = f_merge(w_old, w_m_sel, w_m_lane, w_m_dat);

`ifdef RFPHOENIX_STMERGE_FWD_EN
  logic [AWID-1:0]    r_last_adr;
  logic [LINEWID-1:0] r_last_dat;
  logic               r_last_vld;

  assign w_fwd_hit = r_last_vld && (w_ladr == r_last_adr);
  assign w_old     = (r_state == S_IDLE) ? r_last_dat : i_ram_rdat;

  // Last-written line; invalidate wins over a coincident write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_adr <= '0;
      r_last_dat <= '0;
      r_last_vld <= 1'b0;
    end else begin
      if (r_state == S_WR) begin
        r_last_adr <= r_ladr;
        r_last_dat <= r_ram_wdat;
      end
      r_last_vld <= i_inv ? 1'b0 : ((r_state == S_WR) ? 1'b1 : r_last_vld);
    end
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = i_inv;
  assign w_fwd_hit    = 1'b0;
  assign w_old        = i_ram_rdat;
`endif

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_cap = 1'b1;
          if (w_sel == '0)    w_next = S_DONE;
          else if (w_fwd_hit) w_next = S_WR;
          else                w_next = S_RD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD:   w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == 3'd1) w_next = S_WR;
        else               w_next = S_WAIT;
      end
      S_WR:   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, read-latency counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RD)        r_cnt <= LP_LAT;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      else                        r_cnt <= 3'd0;
      if (r_state == S_DONE) r_ptr <= ~r_win;
    end
  end

  // Winner's request captured once at the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win  <= 1'b0;
      r_sel  <= '0;
      r_lane <= 1'b0;
      r_ladr <= '0;
      r_dat  <= '0;
    end else if (w_cap) begin
      r_win  <= w_win;
      r_sel  <= w_sel;
      r_lane <= w_lane;
      r_ladr <= w_ladr;
      r_dat  <= w_dat;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_rd   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= '0;
      r_ram_wdat <= '0;
    end else begin
      r_ram_rd <= (w_next == S_RD);
      r_ram_we <= (w_next == S_WR);
      r_busy   <= (w_next != S_IDLE);
      r_ack    <= (w_next == S_DONE) ? (w_win_nxt ? 2'b10 : 2'b01) : 2'b00;
      if (w_next == S_WR) r_ram_wdat <= w_merged;
    end
  end

  assign o_ack      = r_ack;
  assign o_busy     = r_busy;
  assign o_ram_rd   = r_ram_rd;
  assign o_ram_we   = r_ram_we;
  assign o_ram_adr  = r_ladr;
  assign o_ram_wdat = r_ram_wdat;

endmodule
